// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use, branch flush, MEM wait with timeout, debug halt.
// Pipeline controls are Mealy outputs of the registered state and the current hazard inputs.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           q2_rs1,
    input  logic [4:0]           q2_rs2,
    input  logic                 q2_uses_rs1,
    input  logic                 q2_uses_rs2,
    input  logic [4:0]           q3_rd,
    input  logic                 q3_mem_read,
    input  logic                 q3_branch_taken,
    input  logic                 q4_mem_req,
    input  logic                 q4_mem_ack,
    input  logic                 halt_req,
    output logic                 pc_en,
    output logic                 q1q2_en,
    output logic                 q1q2_flush,
    output logic                 q2q3_en,
    output logic                 q2q3_flush,
    output logic                 q3q4_en,
    output logic                 q4q5_en,
    output logic                 q4q5_bubble,
    output logic                 halted,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    localparam int WW = $clog2(MEM_TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic [1:0]    drain_cnt;
    logic          ret_drain;
    logic          halt_pend;

    logic mem_stall;
    logic load_use;
    logic halt_want;
    logic wait_last;
    logic enter_drain;
    logic stall_inc;

    assign mem_stall = q4_mem_req & ~q4_mem_ack;
    assign load_use  = q3_mem_read && (q3_rd != 5'd0) &&
                       ((q2_uses_rs1 && (q2_rs1 == q3_rd)) ||
                        (q2_uses_rs2 && (q2_rs2 == q3_rd)));
    // A halt request seen while another event had priority is remembered
    // so a short debug pulse is not lost behind a long MEM wait.
    assign halt_want   = halt_req | halt_pend;
    assign wait_last   = (wait_cnt == WAIT_LAST);
    assign enter_drain = (state == RUN) && !mem_stall && !q3_branch_taken &&
                         !load_use && halt_want;

    always_comb begin
        pc_en       = 1'b1;
        q1q2_en     = 1'b1;
        q1q2_flush  = 1'b0;
        q2q3_en     = 1'b1;
        q2q3_flush  = 1'b0;
        q3q4_en     = 1'b1;
        q4q5_en     = 1'b1;
        q4q5_bubble = 1'b0;
        halted      = 1'b0;
        stall_inc   = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    pc_en       = 1'b0;
                    q1q2_en     = 1'b0;
                    q2q3_en     = 1'b0;
                    q3q4_en     = 1'b0;
                    q4q5_bubble = 1'b1;
                    stall_inc   = 1'b1;
                end else if (q3_branch_taken) begin
                    q1q2_flush = 1'b1;
                    q2q3_flush = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    q1q2_en    = 1'b0;
                    q2q3_flush = 1'b1;
                    stall_inc  = 1'b1;
                end else if (halt_want) begin
                    pc_en      = 1'b0;
                    q1q2_en    = 1'b0;
                    q2q3_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (q4_mem_ack || wait_last) begin
                    // Release (or abandon); while draining, keep fetch frozen.
                    if (ret_drain) begin
                        pc_en      = 1'b0;
                        q1q2_en    = 1'b0;
                        q2q3_flush = 1'b1;
                    end
                    q4q5_bubble = ~q4_mem_ack;
                end else begin
                    pc_en       = 1'b0;
                    q1q2_en     = 1'b0;
                    q2q3_en     = 1'b0;
                    q3q4_en     = 1'b0;
                    q4q5_bubble = 1'b1;
                    stall_inc   = 1'b1;
                end
            end
            DRAIN: begin
                if (mem_stall) begin
                    pc_en       = 1'b0;
                    q1q2_en     = 1'b0;
                    q2q3_en     = 1'b0;
                    q3q4_en     = 1'b0;
                    q4q5_bubble = 1'b1;
                    stall_inc   = 1'b1;
                end else begin
                    pc_en      = 1'b0;
                    q1q2_en    = 1'b0;
                    q2q3_flush = 1'b1;
                end
            end
            HALTED: begin
                pc_en   = 1'b0;
                q1q2_en = 1'b0;
                q2q3_en = 1'b0;
                q3q4_en = 1'b0;
                q4q5_en = 1'b0;
                halted  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            wait_cnt     <= '0;
            drain_cnt    <= 2'd0;
            ret_drain    <= 1'b0;
            halt_pend    <= 1'b0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            case (state)
                RUN: begin
                    halt_pend <= halt_want & ~enter_drain;
                    if (mem_stall) begin
                        state     <= MEM_WAIT;
                        wait_cnt  <= WW'(1);
                        ret_drain <= 1'b0;
                    end else if (enter_drain) begin
                        // The entry cycle is drain cycle 0.
                        state     <= DRAIN;
                        drain_cnt <= 2'd1;
                    end
                end
                MEM_WAIT: begin
                    halt_pend <= ret_drain ? 1'b0 : (halt_pend | halt_req);
                    if (q4_mem_ack || wait_last) begin
                        state    <= ret_drain ? DRAIN : RUN;
                        wait_cnt <= '0;
                        if (!q4_mem_ack) begin
                            mem_timeout <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                DRAIN: begin
                    halt_pend <= 1'b0;
                    if (mem_stall) begin
                        state     <= MEM_WAIT;
                        wait_cnt  <= WW'(1);
                        ret_drain <= 1'b1;
                    end else if (drain_cnt == 2'd2) begin
                        state     <= HALTED;
                        drain_cnt <= 2'd0;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                HALTED: begin
                    halt_pend <= 1'b0;
                    ret_drain <= 1'b0;
                    if (!halt_req) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
            if (stall_inc && (stall_cycles != {CNT_WIDTH{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a randomized run against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MT = 16;
    // {pc_en, q1q2_en, q1q2_flush, q2q3_en, q2q3_flush, q3q4_en, q4q5_en, q4q5_bubble, halted}
    localparam logic [8:0] C_DEF   = 9'b110101100;
    localparam logic [8:0] C_STALL = 9'b000000110;
    localparam logic [8:0] C_BR    = 9'b111111100;
    localparam logic [8:0] C_LU    = 9'b000111100;
    localparam logic [8:0] C_DRAIN = 9'b000111100;
    localparam logic [8:0] C_HALT  = 9'b000000001;
    localparam logic [8:0] C_TO    = 9'b110101110;

    logic       clk;
    logic       rst_n;
    logic [4:0] q2_rs1, q2_rs2, q3_rd;
    logic       q2_uses_rs1, q2_uses_rs2, q3_mem_read, q3_branch_taken;
    logic       q4_mem_req, q4_mem_ack, halt_req;

    logic        pc_en, q1q2_en, q1q2_flush, q2q3_en, q2q3_flush, q3q4_en, q4q5_en, q4q5_bubble, halted;
    logic        mem_timeout;
    logic [15:0] stall_cycles;
    logic        s_pc_en, s_q1q2_en, s_q1q2_flush, s_q2q3_en, s_q2q3_flush, s_q3q4_en, s_q4q5_en;
    logic        s_q4q5_bubble, s_halted, s_mem_timeout;
    logic [3:0]  s_stall_cycles;

    logic [8:0] ctrl, s_ctrl;
    assign ctrl   = {pc_en, q1q2_en, q1q2_flush, q2q3_en, q2q3_flush, q3q4_en, q4q5_en, q4q5_bubble, halted};
    assign s_ctrl = {s_pc_en, s_q1q2_en, s_q1q2_flush, s_q2q3_en, s_q2q3_flush, s_q3q4_en, s_q4q5_en,
                     s_q4q5_bubble, s_halted};

    int n_vec = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .q2_rs1(q2_rs1), .q2_rs2(q2_rs2), .q2_uses_rs1(q2_uses_rs1), .q2_uses_rs2(q2_uses_rs2),
        .q3_rd(q3_rd), .q3_mem_read(q3_mem_read), .q3_branch_taken(q3_branch_taken),
        .q4_mem_req(q4_mem_req), .q4_mem_ack(q4_mem_ack), .halt_req(halt_req),
        .pc_en(pc_en), .q1q2_en(q1q2_en), .q1q2_flush(q1q2_flush), .q2q3_en(q2q3_en),
        .q2q3_flush(q2q3_flush), .q3q4_en(q3q4_en), .q4q5_en(q4q5_en), .q4q5_bubble(q4q5_bubble),
        .halted(halted), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .q2_rs1(q2_rs1), .q2_rs2(q2_rs2), .q2_uses_rs1(q2_uses_rs1), .q2_uses_rs2(q2_uses_rs2),
        .q3_rd(q3_rd), .q3_mem_read(q3_mem_read), .q3_branch_taken(q3_branch_taken),
        .q4_mem_req(q4_mem_req), .q4_mem_ack(q4_mem_ack), .halt_req(halt_req),
        .pc_en(s_pc_en), .q1q2_en(s_q1q2_en), .q1q2_flush(s_q1q2_flush), .q2q3_en(s_q2q3_en),
        .q2q3_flush(s_q2q3_flush), .q3q4_en(s_q3q4_en), .q4q5_en(s_q4q5_en),
        .q4q5_bubble(s_q4q5_bubble), .halted(s_halted), .mem_timeout(s_mem_timeout),
        .stall_cycles(s_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: tracks what the pipe is doing in plain terms.
    bit m_waiting, m_draining, m_halted, m_back_to_drain, m_pending, m_timed_out;
    int m_waited, m_drained, m_count;

    task automatic model_reset();
        m_waiting = 0; m_draining = 0; m_halted = 0; m_back_to_drain = 0;
        m_pending = 0; m_timed_out = 0; m_waited = 0; m_drained = 0; m_count = 0;
    endtask

    task automatic model_step(output logic [8:0] e);
        bit hz, stall_now, want;
        hz = q3_mem_read && (q3_rd != 0) &&
             ((q2_uses_rs1 && q2_rs1 == q3_rd) || (q2_uses_rs2 && q2_rs2 == q3_rd));
        stall_now = q4_mem_req && !q4_mem_ack;
        want = halt_req || m_pending;
        if (halt_req && !m_halted && !m_draining) m_pending = 1;
        e = C_DEF;
        if (m_halted) begin
            e = C_HALT;
            if (!halt_req) m_halted = 0;
        end else if (m_waiting) begin
            if (q4_mem_ack || m_waited == MT - 1) begin
                e = m_back_to_drain ? C_DRAIN : C_DEF;
                if (!q4_mem_ack) begin e[1] = 1'b1; m_timed_out = 1; end
                m_waiting = 0;
            end else begin
                e = C_STALL; m_waited++; m_count++;
            end
        end else if (stall_now) begin
            e = C_STALL; m_waiting = 1; m_waited = 1; m_count++; m_back_to_drain = m_draining;
        end else if (m_draining) begin
            e = C_DRAIN; m_drained++;
            if (m_drained == 3) begin m_draining = 0; m_halted = 1; end
        end else if (q3_branch_taken) begin
            e = C_BR;
        end else if (hz) begin
            e = C_LU; m_count++;
        end else if (want) begin
            e = C_DRAIN; m_draining = 1; m_drained = 1; m_pending = 0;
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                          input logic [4:0] rd, input logic mr, input logic br, input logic req,
                          input logic ack, input logic hr);
        q2_rs1 = rs1; q2_rs2 = rs2; q2_uses_rs1 = u1; q2_uses_rs2 = u2; q3_rd = rd;
        q3_mem_read = mr; q3_branch_taken = br; q4_mem_req = req; q4_mem_ack = ack; halt_req = hr;
    endtask

    // One clock: inputs change just after the rising edge, outputs are observed at the falling edge.
    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic [4:0] rd, input logic mr, input logic br, input logic req,
                         input logic ack, input logic hr);
        @(posedge clk); #1;
        set_in(rs1, rs2, u1, u2, rd, mr, br, req, ack, hr);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        n_vec++; if (ctrl !== C_DEF) begin n_err++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_DEF); end
        n_vec++; if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", stall_cycles); end
        n_vec++; if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL reset_mt: got %b want 0", mem_timeout); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(7, 5, 1, 1, 5, 1, 0, 0, 0, 0);
        n_vec++; if (ctrl !== C_LU) begin n_err++; $display("FAIL lu_ctrl: got %b want %b", ctrl, C_LU); end
        idle();
        n_vec++; if (ctrl !== C_DEF) begin n_err++; $display("FAIL lu_one_cycle: got %b want %b", ctrl, C_DEF); end
        n_vec++; if (stall_cycles !== 16'd1) begin n_err++; $display("FAIL lu_count: got %0d want 1", stall_cycles); end
        drive(7, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        n_vec++; if (ctrl !== C_DEF) begin n_err++; $display("FAIL lu_rd0: got %b want %b", ctrl, C_DEF); end
        idle();
        n_vec++; if (stall_cycles !== 16'd1) begin n_err++; $display("FAIL lu_rd0_count: got %0d want 1", stall_cycles); end
    endtask

    task automatic test_branch_vs_load();
        do_reset();
        drive(5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
        n_vec++; if (ctrl !== C_BR) begin n_err++; $display("FAIL br_over_lu: got %b want %b", ctrl, C_BR); end
        idle();
        n_vec++; if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL br_count: got %0d want 0", stall_cycles); end
    endtask

    task automatic test_mem_wait();
        logic [8:0] e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, (i == 3), 0);
            e = (i == 3) ? C_DEF : C_STALL;
            n_vec++; if (ctrl !== e) begin n_err++; $display("FAIL memwait_c%0d: got %b want %b", i, ctrl, e); end
        end
        idle();
        n_vec++; if (stall_cycles !== 16'd3) begin n_err++; $display("FAIL memwait_count: got %0d want 3", stall_cycles); end
    endtask

    task automatic test_timeout_saturation();
        logic [8:0] e;
        do_reset();
        for (int i = 0; i < MT; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            e = (i == MT - 1) ? C_TO : C_STALL;
            n_vec++; if (ctrl !== e) begin n_err++; $display("FAIL to_c%0d: got %b want %b", i, ctrl, e); end
        end
        n_vec++; if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL to_early: got %b want 0", mem_timeout); end
        idle();
        n_vec++; if (mem_timeout !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b want 1", mem_timeout); end
        n_vec++; if (stall_cycles !== 16'd15) begin n_err++; $display("FAIL to_count: got %0d want 15", stall_cycles); end
        for (int i = 0; i < 6; i++) drive(0, 9, 0, 1, 9, 1, 0, 0, 0, 0);
        idle();
        n_vec++; if (stall_cycles !== 16'd21) begin n_err++; $display("FAIL sat_wide: got %0d want 21", stall_cycles); end
        n_vec++; if (s_stall_cycles !== 4'd15) begin n_err++; $display("FAIL sat_narrow: got %0d want 15", s_stall_cycles); end
        n_vec++; if (mem_timeout !== 1'b1) begin n_err++; $display("FAIL to_hold: got %b want 1", mem_timeout); end
    endtask

    task automatic test_reset_mid_wait();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        n_vec++; if (ctrl !== C_DEF) begin n_err++; $display("FAIL rst_mid_ctrl: got %b want %b", ctrl, C_DEF); end
        n_vec++; if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL rst_mid_cnt: got %0d want 0", stall_cycles); end
        n_vec++; if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL rst_mid_mt: got %b want 0", mem_timeout); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        n_vec++; if (ctrl !== C_DEF) begin n_err++; $display("FAIL zero_wait: got %b want %b", ctrl, C_DEF); end
        idle();
        n_vec++; if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL zero_wait_cnt: got %0d want 0", stall_cycles); end
    endtask

    task automatic test_halt();
        logic [11:0] req_v, ack_v, hr_v;
        logic [8:0]  exp_v [12];
        req_v = 12'b111011000000;
        ack_v = 12'b001001000000;
        hr_v  = 12'b100000011100;
        exp_v = '{C_STALL, C_STALL, C_DEF, C_DRAIN, C_STALL, C_DRAIN, C_DRAIN, C_DRAIN,
                  C_HALT, C_HALT, C_HALT, C_DEF};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, req_v[11-i], ack_v[11-i], hr_v[11-i]);
            n_vec++; if (ctrl !== exp_v[i]) begin n_err++; $display("FAIL halt_c%0d: got %b want %b", i, ctrl, exp_v[i]); end
        end
        n_vec++; if (stall_cycles !== 16'd3) begin n_err++; $display("FAIL halt_count: got %0d want 3", stall_cycles); end
    endtask

    task automatic test_random();
        logic [8:0]  e;
        logic [15:0] want_wide;
        logic [3:0]  want_narrow;
        logic        req, ack, hr;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (m_waiting) begin
                req = 1'b1; ack = ($urandom_range(0, 9) < 2);
            end else begin
                req = ($urandom_range(0, 3) == 0); ack = $urandom_range(0, 1) == 1;
            end
            hr = m_halted ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0, req, ack, hr);
            want_wide   = (m_count > 65535) ? 16'hffff : 16'(m_count);
            want_narrow = (m_count > 15) ? 4'hf : 4'(m_count);
            n_vec++; if (stall_cycles !== want_wide) begin n_err++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, stall_cycles, want_wide); end
            n_vec++; if (s_stall_cycles !== want_narrow) begin n_err++; $display("FAIL rnd_sat c%0d: got %0d want %0d", c, s_stall_cycles, want_narrow); end
            n_vec++; if (mem_timeout !== m_timed_out) begin n_err++; $display("FAIL rnd_mt c%0d: got %b want %b", c, mem_timeout, m_timed_out); end
            model_step(e);
            n_vec++; if (ctrl !== e) begin n_err++; $display("FAIL rnd_ctrl c%0d: got %b want %b", c, ctrl, e); end
            n_vec++; if (s_ctrl !== e) begin n_err++; $display("FAIL rnd_ctrl_sat c%0d: got %b want %b", c, s_ctrl, e); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_load_use();
        test_branch_vs_load();
        test_mem_wait();
        test_timeout_saturation();
        test_reset_mid_wait();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage core (q1=IF, q2=ID, q3=EX, q4=MEM, q5=WB).
- Drives the per-stage enable and flush controls of the q1q2/q2q3/q3q4/q4q5 pipeline registers and the PC enable.
- Resolves load-use hazards, taken-branch flushes, multi-cycle data-memory waits with timeout, and debug halt/drain/resume.
- Control outputs are combinational from registered state plus current inputs (Mealy).

Parameters:
MEM_TIMEOUT, 16, cycles a single MEM access may hold the pipe before it is abandoned (>=2)
CNT_WIDTH, 16, width of the saturating stall_cycles performance counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
q2_rs1  in  5  rs1 of instruction in ID
q2_rs2  in  5  rs2 of instruction in ID
q2_uses_rs1  in  1  ID instruction reads rs1
q2_uses_rs2  in  1  ID instruction reads rs2
q3_rd  in  5  destination of instruction in EX
q3_mem_read  in  1  EX instruction is a load
q3_branch_taken  in  1  EX resolved a taken branch/jump
q4_mem_req  in  1  MEM stage data access outstanding
q4_mem_ack  in  1  data memory completes access this cycle
halt_req  in  1  debug halt request (level)
pc_en  out  1  PC update enable
q1q2_en  out  1  IF/ID register enable
q1q2_flush  out  1  load NOP into IF/ID
q2q3_en  out  1  ID/EX register enable
q2q3_flush  out  1  load bubble (instr 0x00000013, ctrl 0) into ID/EX
q3q4_en  out  1  EX/MEM register enable
q4q5_en  out  1  MEM/WB register enable
q4q5_bubble  out  1  load bubble into MEM/WB
halted  out  1  core fully drained and frozen
mem_timeout  out  1  sticky: an access was abandoned
stall_cycles  out  CNT_WIDTH  saturating count of load-use + MEM-wait stall cycles

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALTED. Reset: state=RUN, wait_cnt=0, drain_cnt=0, mem_timeout=0, stall_cycles=0.
- Default (RUN, no event): all *_en=1, all flush/bubble=0, halted=0.
- Priority, evaluated each cycle in RUN: mem stall > branch flush > load-use > halt entry.
- Mem stall, RUN, q4_mem_req=1 and q4_mem_ack=0:
  - Same cycle: all *_en=0 except q4q5_en=1; q4q5_bubble=1.
  - Next state MEM_WAIT; wait_cnt=1.
- Zero-wait access (req and ack together in RUN): no stall.
- MEM_WAIT:
  - Same outputs as the mem stall cycle.
  - ack=1: default outputs (release) this cycle, bubble=0, next RUN.
  - ack=0 and wait_cnt==MEM_TIMEOUT-1: access abandoned; all *_en=1, q4q5_bubble=1; next RUN; mem_timeout set at the edge.
  - Otherwise: wait_cnt increments.
  - Total stalled cycles before timeout release = MEM_TIMEOUT-1.
- Branch flush (RUN, q3_branch_taken, no mem stall): all *_en=1, q1q2_flush=1, q2q3_flush=1. One cycle, no state change. Overrides a simultaneous load-use.
- Load-use (RUN): hazard when q3_mem_read=1 and q3_rd!=0 and ((q2_uses_rs1 and q2_rs1==q3_rd) or (q2_uses_rs2 and q2_rs2==q3_rd)).
  - Response: pc_en=0, q1q2_en=0, q2q3_flush=1; other enables 1. One cycle.
- Halt entry: RUN, halt_req=1, no other event that cycle. Otherwise entry is deferred.
  - Entry cycle acts as DRAIN cycle 0; next DRAIN, drain_cnt=1.
- DRAIN: pc_en=0, q1q2_en=0 (ID instruction held for resume), q2q3_flush=1, q3q4_en=q4q5_en=1.
  - After 3 drain cycles total: next HALTED.
  - Mem stall during DRAIN: stall outputs apply, drain_cnt frozen, return to DRAIN after release.
  - halt_req deassert during DRAIN does not abort the drain.
- HALTED: all *_en=0, flushes 0, halted=1. halt_req=0 → next RUN; first RUN cycle uses default outputs.
- stall_cycles: +1 on each load-use cycle and each mem-stalled cycle (entry and MEM_WAIT; not release/timeout cycles). Saturates at all-ones.
- mem_timeout clears only on reset.
- Reset asserted mid-operation: immediate return to reset values in any state.

Test Plan:
- Load x5 in EX; ID add uses rs2=x5 → exactly 1 cycle pc_en=0, q1q2_en=0, q2q3_flush=1; stall_cycles=1. Repeat with q3_rd=0 → no stall.
- Load-use and q3_branch_taken in the same cycle → q1q2_flush=q2q3_flush=1, pc_en=1; stall_cycles unchanged.
- q4_mem_req high, ack on 4th cycle → 3 cycles all *_en=0 except q4q5 with bubble, 4th cycle release; stall_cycles=3.
- MEM_TIMEOUT=16, ack never → 15 stalled cycles, release with q4q5_bubble=1 on 16th; mem_timeout=1 thereafter.
- halt_req pulse while mem stalled → drain begins after release; DRAIN lasts 3 cycles (extended by any stall), halted=1. Drop halt_req → RUN next cycle, held ID instruction issues.
- Force 2^CNT_WIDTH+5 stall cycles (CNT_WIDTH=4) → stall_cycles=15. Assert rst_n low mid-MEM_WAIT → state RUN, counters 0, mem_timeout=0.
